// File: rtl/mist1032isa_async_fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// mist1032isa_async_fifo_rd_packer: packs PACK show-ahead FIFO entries per
// word into a 2-entry valid/busy queue. Option: MIST1032ISA_ASYNC_FIFO_RD_PACKER_PARITY_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mist1032isa_async_fifo_rd_packer #(
  parameter int N      = 16,
  parameter int PACK   = 2,
  parameter int PACK_N = 1
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iREMOVE,
  input  logic                iFIFO_EMPTY,
  input  logic [N-1:0]        iFIFO_DATA,
  output logic                oFIFO_RD_EN,
  output logic                oVALID,
  output logic [N*PACK-1:0]   oDATA,
`ifdef MIST1032ISA_ASYNC_FIFO_RD_PACKER_PARITY_EN
  output logic                oPARITY,
`endif
  input  logic                iBUSY,
  output logic                oPARTIAL
);

  localparam int W = N * PACK;
`ifdef MIST1032ISA_ASYNC_FIFO_RD_PACKER_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int EW = W + PW;
  localparam logic [PACK_N-1:0] LAST = PACK_N'(PACK - 1);

  logic [PACK_N-1:0] b_pack_cnt;
  logic [W-1:0]      pack_reg;
  logic [W-1:0]      merged;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     q_head;
  logic [EW-1:0]     q_tail;
  logic [1:0]        q_cnt;
  logic              room;
  logic              pop;
  logic              push;
  logic              deq;

  // Room is judged on the registered queue count only, so a same-cycle
  // dequeue never opens a slot for the completing pop.
  assign room        = (b_pack_cnt != LAST) || (q_cnt != 2'd2);
  assign pop         = inRESET && !iFIFO_EMPTY && !iREMOVE && room;
  assign push        = pop && (b_pack_cnt == LAST);
  assign deq         = (q_cnt != 2'd0) && !iBUSY;
  assign oFIFO_RD_EN = pop;

  always_comb begin
    merged = pack_reg;
    merged[int'(b_pack_cnt)*N +: N] = iFIFO_DATA;
  end

`ifdef MIST1032ISA_ASYNC_FIFO_RD_PACKER_PARITY_EN
  assign push_entry = {^merged, merged};
  assign oPARITY    = q_head[EW-1];
`else
  assign push_entry = merged;
`endif

  assign oVALID   = (q_cnt != 2'd0);
  assign oDATA    = q_head[W-1:0];
  assign oPARTIAL = (b_pack_cnt != '0);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_pack_cnt <= '0;
      pack_reg   <= '0;
      q_cnt      <= 2'd0;
      q_head     <= '0;
      q_tail     <= '0;
    end else if (iREMOVE) begin
      b_pack_cnt <= '0;
      pack_reg   <= '0;
      q_cnt      <= 2'd0;
      q_head     <= '0;
      q_tail     <= '0;
    end else begin
      if (pop) begin
        if (push) begin
          b_pack_cnt <= '0;
          pack_reg   <= '0;
        end else begin
          b_pack_cnt <= b_pack_cnt + 1'b1;
          pack_reg   <= merged;
        end
      end
      // Entries beyond q_cnt are kept at zero so the head reads 0 when idle.
      case ({push, deq})
        2'b10: begin
          if (q_cnt == 2'd0) q_head <= push_entry;
          else               q_tail <= push_entry;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          q_head <= q_tail;
          q_tail <= '0;
          q_cnt  <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q_head <= push_entry;
          end else begin
            q_head <= q_tail;
            q_tail <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
